// File: rtl/cache_mem_responder.sv
// Memory-side line responder: fixed-latency read/write of 128-bit lines with a one-cycle mem_ready.
// Optional sticky protocol checker on mem_proto_err, enabled by defining MEM_PROTOCOL_CHECK_EN.
//   state | meaning
//   IDLE  | no transaction in progress, waiting for mem_read/mem_write
//   BUSY  | request latched, counting down the latency
//   DONE  | operation performed, mem_ready high for this cycle only
module cache_mem_responder #(
    parameter int NUM_LINES      = 256,
    parameter int LINE_ADDR_SIZE = 8,
    parameter int LATENCY        = 4
) (
    input  logic         clk,
    input  logic         mem_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic         mem_proto_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      op_wr_q, op_wr_d;
    logic [LINE_ADDR_SIZE-1:0] idx_q, idx_d;
    logic [127:0]              wdata_q, wdata_d;
    logic [127:0]              rdata_q, rdata_d;
    logic [127:0]              mem_array_q [NUM_LINES];

    logic                      req;
    logic                      fire;
    logic                      fire_wr;
    logic [LINE_ADDR_SIZE-1:0] fire_idx;
    logic [127:0]              fire_wdata;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (!mem_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // With LATENCY=1 the op completes at the acceptance edge, so it uses the live inputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        fire       = 1'b0;
        fire_wr    = op_wr_q;
        fire_idx   = idx_q;
        fire_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_wr_d = mem_write;
                    idx_d   = mem_addr[LINE_ADDR_SIZE-1:0];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = S_DONE;
                        fire       = 1'b1;
                        fire_wr    = mem_write;
                        fire_idx   = mem_addr[LINE_ADDR_SIZE-1:0];
                        fire_wdata = mem_wdata;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = 4'(cnt_q - 4'd1);
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    fire    = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == S_DONE);
        rdata_d   = rdata_q;
        if (fire && !fire_wr) begin
            rdata_d = mem_array_q[fire_idx];
        end
    end

    assign mem_rdata = rdata_q;

    // Array is deliberately not reset; an aborting reset must also block the write.
    always_ff @(posedge clk) begin
        if (mem_reset_n && fire && fire_wr) begin
            mem_array_q[fire_idx] <= fire_wdata;
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[27:LINE_ADDR_SIZE];

`ifdef MEM_PROTOCOL_CHECK_EN
    logic [27:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        busy;

    assign busy = (state_q == S_BUSY);

    always_comb begin
        addr_d = addr_q;
        if (state_q == S_IDLE && req) begin
            addr_d = mem_addr;
        end
        err_d = err_q
              | (mem_read & mem_write)
              | (busy & ~req)
              | (busy & (mem_addr != addr_q))
              | (busy & op_wr_q & (mem_wdata != wdata_q));
    end

    always_ff @(posedge clk) begin
        if (!mem_reset_n) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign mem_proto_err = err_q;
`endif

endmodule
